// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver for the Nios txd line. It oversamples the line
// 16x per bit, recovers bytes and buffers them in a show-ahead FIFO.
// Default framing is 8N1. Defining UART_RX_PARITY_EN selects 8E1 framing and
// adds the perr pulse output.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rxd,
  input  logic                        rd_en,
  output logic [7:0]                  rd_data,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        frame_err,
  output logic                        overrun,
`ifdef UART_RX_PARITY_EN
  output logic                        perr,
`endif
  output logic                        busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t state, state_nxt;

  logic             sync1, rxs;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             push_req;
  logic             bit_end, mid_start;
  logic             enter_start, shift_en, stop_ok, stop_bad;
`ifdef UART_RX_PARITY_EN
  logic             par_bad, par_ok;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // Two-flop synchronizer for the asynchronous serial line; resets to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  assign tick      = (div_cnt == DIV_LAST);
  assign bit_end   = tick && (tick_cnt == 4'd15);
  assign mid_start = tick && (tick_cnt == 4'd7);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!rxs) state_nxt = START;
      START:  if (mid_start) state_nxt = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (bit_end && (bit_idx == 3'd7)) state_nxt = PARITY;
      PARITY: if (bit_end) state_nxt = STOP;
`else
      DATA:   if (bit_end && (bit_idx == 3'd7)) state_nxt = STOP;
`endif
      STOP:   if (bit_end) state_nxt = rxs ? IDLE : BREAK;
      BREAK:  if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded strobes for the datapath.
  always_comb begin
    busy        = (state != IDLE);
    enter_start = (state == IDLE) && !rxs;
    shift_en    = (state == DATA) && bit_end;
    stop_ok     = (state == STOP) && bit_end && rxs;
    stop_bad    = (state == STOP) && bit_end && !rxs;
`ifdef UART_RX_PARITY_EN
    par_bad     = (state == PARITY) && bit_end && (rxs != ^shift);
`endif
  end

  // Oversample counters, data shift register and error/push strobes.
  // The shift register is not touched again until the next frame's DATA
  // phase, so it feeds the FIFO directly in the cycle after the stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      push_req  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok    <= 1'b1;
      perr      <= 1'b0;
`endif
    end else begin
      if (enter_start || tick) div_cnt <= '0;
      else                     div_cnt <= div_cnt + DIV_W'(1);

      if (state == IDLE || state == BREAK)
        tick_cnt <= '0;
      else if (tick)
        tick_cnt <= (state == START && tick_cnt == 4'd7) ? 4'd0 : tick_cnt + 4'd1;

      if (state == START)  bit_idx <= '0;
      else if (shift_en)   bit_idx <= bit_idx + 3'd1;

      if (shift_en) shift[bit_idx] <= rxs;

      frame_err <= stop_bad;
`ifdef UART_RX_PARITY_EN
      if (state == START) par_ok <= 1'b1;
      else if (par_bad)   par_ok <= 1'b0;
      perr     <= par_bad;
      push_req <= stop_ok && par_ok;
`else
      push_req <= stop_ok;
`endif
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = rd_en && !empty;
  assign do_push = push_req && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Show-ahead FIFO; a push into a full FIFO survives only with a same-cycle pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[AW'(i)] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push_req && full && !do_pop;
      if (do_push) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
